// File: rtl/layer_out_collector.sv
// Collects one NN layer's output vector over valid/ready and exposes it to a host
// with registered random-access readback and a released-vector count. `ARGMAX_EN adds a running argmax.
module layer_out_collector #(
  parameter  int unsigned M  = 8,
  parameter  int unsigned W  = 16,
  localparam int unsigned AW = $clog2(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [W-1:0]  data_in,
  output logic          vec_valid,
  input  logic          vec_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic [7:0]    vec_count,
  output logic [AW-1:0] max_idx,
  output logic [W-1:0]  max_val
);

  typedef enum logic {RECV, FULL} state_t;

  state_t        state, next_state;
  logic [AW-1:0] wr_idx;
  logic [W-1:0]  vec_buf [M];
  logic          accept_c, release_c, last_c;

  always_ff @(posedge clk) begin
    if (reset) state <= RECV;
    else       state <= next_state;
  end

  // Upstream is held off while reset is asserted even though the state is already RECV.
  assign s_ready   = (state == RECV) && !reset;
  assign vec_valid = (state == FULL);
  assign last_c    = (wr_idx == AW'(M - 1));

  always_comb begin
    next_state = state;
    accept_c   = 1'b0;
    release_c  = 1'b0;
    case (state)
      RECV: begin
        accept_c = s_valid && s_ready;
        if (accept_c && last_c) next_state = FULL;
      end
      FULL: begin
        release_c = vec_ready;
        if (vec_ready) next_state = RECV;
      end
      default: next_state = RECV;
    endcase
  end

  // Vector storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (accept_c) vec_buf[wr_idx] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx    <= '0;
      vec_count <= '0;
      rd_data   <= '0;
    end else begin
      if (accept_c) wr_idx <= last_c ? '0 : AW'(wr_idx + 1'b1);
      if (release_c) vec_count <= vec_count + 8'd1;
      rd_data <= (32'(rd_addr) < M) ? vec_buf[rd_addr] : '0;
    end
  end

`ifdef ARGMAX_EN
  // Word 0 seeds the max; later words win only on strictly greater, so ties keep the lowest index.
  always_ff @(posedge clk) begin
    if (reset) begin
      max_idx <= '0;
      max_val <= '0;
    end else if (accept_c && ((wr_idx == '0) || ($signed(data_in) > $signed(max_val)))) begin
      max_idx <= wr_idx;
      max_val <= data_in;
    end
  end
`else
  assign max_idx = '0;
  assign max_val = '0;
`endif

endmodule

// File: tb/tb_layer_out_collector.sv
// Scoreboarded bench for layer_out_collector: readback expectations are queued at
// issue time and checked by a monitor when the registered read data appears.
module tb_layer_out_collector;

  logic        clk = 1'b0;
  logic        reset, s_valid, s_ready, vec_valid, vec_ready;
  logic [15:0] data_in, rd_data, max_val;
  logic [2:0]  rd_addr, max_idx;
  logic [7:0]  vec_count;

  logic rd_req   = 1'b0;
  logic rd_req_d = 1'b0;
  int   exp_q[$];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   accept_cnt = 0;
  int   exp_count  = 0;

  layer_out_collector #(.M(8), .W(16)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .data_in(data_in), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .vec_count(vec_count),
    .max_idx(max_idx), .max_val(max_val)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    rd_req_d <= rd_req;
    if (s_valid && s_ready) accept_cnt <= accept_cnt + 1;
  end

  // Read data monitor: one registered result per read issued on the previous edge.
  always @(negedge clk) begin
    int e;
    if (rd_req_d) begin
      if (exp_q.size() == 0) check("rd_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("rd_data", int'($signed(rd_data)), e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int w[8], input int lo, input int hi, input bit gap);
    for (int i = lo; i < hi; i++) begin
      int n = 0;
      s_valid = 1'b1;
      data_in = 16'(w[i]);
      while (!s_ready && n < 50) begin
        tick();
        n++;
      end
      if (n >= 50) check("stream_timeout", 0, 1);
      tick();
      if (gap) begin
        s_valid = 1'b0;
        tick();
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic read_vec(input int w[8]);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      rd_req  = 1'b1;
      exp_q.push_back(w[i]);
      tick();
    end
    rd_req = 1'b0;
    tick();
  endtask

  task automatic release_vec();
    vec_ready = 1'b1;
    tick();
    vec_ready = 1'b0;
    exp_count = (exp_count + 1) % 256;
    check("rel_vec_valid", int'(vec_valid), 0);
    check("rel_s_ready", int'(s_ready), 1);
    check("rel_vec_count", int'(vec_count), exp_count);
  endtask

  task automatic check_argmax(input string name, input int idx, input int val);
`ifdef ARGMAX_EN
    check({name, "_idx"}, int'(max_idx), idx);
    check({name, "_val"}, int'($signed(max_val)), val);
`else
    check({name, "_idx"}, int'(max_idx), 0);
    check({name, "_val"}, int'($signed(max_val)), 0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v1[8], v2[8], v3[8], v4[8], v5[8], v6[8];
    int a;
    v1 = '{10, 20, 30, 40, 50, 60, 70, 80};
    v2 = '{11, -22, 33, -44, 55, -66, 77, -88};
    v3 = '{-5, 3, -128, 3, 7, 7, -1, 0};
    v4 = '{-9, -2, -2, -3, -4, -5, -6, -7};
    v5 = '{1, 2, 3, 4, 5, 6, 7, 8};
    v6 = '{50, 51, 52, 53, 54, 0, 0, 0};

    reset = 1'b1; s_valid = 1'b0; vec_ready = 1'b0; rd_addr = '0; data_in = '0;
    tick(); tick();
    check("reset_s_ready", int'(s_ready), 0);
    check("reset_vec_valid", int'(vec_valid), 0);
    check("reset_rd_data", int'(rd_data), 0);
    check("reset_vec_count", int'(vec_count), 0);
    check_argmax("reset_max", 0, 0);
    reset = 1'b0;
    #1;
    check("post_reset_s_ready", int'(s_ready), 1);

    // Back-to-back stream, vec_valid the cycle after the last accept.
    a = accept_cnt;
    stream(v1, 0, 7, 1'b0);
    check("t1_vec_valid_early", int'(vec_valid), 0);
    stream(v1, 7, 8, 1'b0);
    check("t1_vec_valid", int'(vec_valid), 1);
    check("t1_accepts", accept_cnt - a, 8);
    read_vec(v1);

    // Hold FULL with upstream pushing; buffer must not change and no bypass on release.
    s_valid = 1'b1;
    data_in = 16'd999;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t3_s_ready_hold", int'(s_ready), 0);
    end
    check("t3_vec_valid_hold", int'(vec_valid), 1);
    a = accept_cnt;
    read_vec(v1);
    release_vec();
    s_valid = 1'b0;
    check("t3_no_bypass", accept_cnt - a, 0);

    // Toggled s_valid.
    a = accept_cnt;
    stream(v2, 0, 8, 1'b1);
    check("t2_accepts", accept_cnt - a, 8);
    check("t2_vec_valid", int'(vec_valid), 1);
    read_vec(v2);
    release_vec();

    // Argmax with ties and all-negative vector.
    stream(v3, 0, 8, 1'b0);
    check_argmax("t4a", 4, 7);
    read_vec(v3);
    release_vec();
    stream(v4, 0, 8, 1'b1);
    check_argmax("t4b", 1, -2);
    release_vec();

    // Reset mid-vector discards partial data and the count.
    stream(v6, 0, 5, 1'b0);
    reset = 1'b1;
    tick();
    check("t5_s_ready_in_reset", int'(s_ready), 0);
    tick();
    reset = 1'b0;
    #1;
    exp_count = 0;
    check("t5_vec_count", int'(vec_count), 0);
    check("t5_s_ready", int'(s_ready), 1);
    stream(v5, 0, 7, 1'b0);
    check("t5_vec_valid_early", int'(vec_valid), 0);
    stream(v5, 7, 8, 1'b0);
    check("t5_vec_valid", int'(vec_valid), 1);
    read_vec(v5);
    check("t5_vec_count_full", int'(vec_count), 0);

    // Reset while FULL drops the vector.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("t5_reset_full_vec_valid", int'(vec_valid), 0);

    // 256 releases wrap the count; vec_ready in RECV is ignored.
    for (int k = 0; k < 256; k++) begin
      stream(v1, 0, 8, 1'b0);
      release_vec();
    end
    check("t6_wrap", int'(vec_count), 0);
    vec_ready = 1'b1;
    tick();
    tick();
    vec_ready = 1'b0;
    check("t6_recv_vec_ready", int'(vec_count), 0);
    check("t6_recv_vec_valid", int'(vec_valid), 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
